bbox_arbiter: RTL

BBOX_ARBITER -- requirements
Module: bbox_arbiter

---
 rtl/bbox_arbiter_pkg.sv | 26 ++
 rtl/bbox_arbiter_rr_picker.sv | 29 ++
 rtl/bbox_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bbox_arbiter_pkg.sv
// Shared types for the bounding-box arbiter: FSM states, bbox lane indices
// and the packed vertex array handed to the bounding_box_calc engine.
package bbox_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_CALC,
      ST_RESPOND,
      ST_RELEASE
   } state_t;

   localparam int COORD_W = 32;
   localparam int MIN_X   = 0;
   localparam int MAX_X   = 1;
   localparam int MIN_Y   = 2;
   localparam int MAX_Y   = 3;

   // [vertex][0=x,1=y][bit]: vertex v coordinate c sits at bits (v*2+c)*32
   typedef logic [2:0][1:0][COORD_W-1:0] vtx_arr_t;
   typedef logic [3:0][COORD_W-1:0]      bbox_t;

   localparam int VTX_W  = $bits(vtx_arr_t);
   localparam int BBOX_W = $bits(bbox_t);

endpackage

// File: rtl/bbox_arbiter_rr_picker.sv
// Round-robin winner search: first asserted request strictly after i_last,
// wrapping modulo NUM_REQ, so the last-served requester has lowest priority.
module rr_picker
   import bbox_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_last,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_found
);

   always_comb begin
      int j;
      j       = 0;
      o_idx   = '0;
      o_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(i_last) + k) % NUM_REQ;
         if (!o_found && i_req[j]) begin
            o_found = 1'b1;
            o_idx   = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/bbox_arbiter.sv
// Shares one bounding_box_calc among NUM_REQ triangle-setup requesters, one
// transaction at a time. Define BBOX_ARB_TIMEOUT_EN to enable the calc_done watchdog.
module bbox_arbiter
   import bbox_arbiter_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*VTX_W-1:0] req_pts,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     calc_ready,
   output logic                     calc_data_valid,
   output logic [VTX_W-1:0]         calc_pts,
   input  logic                     calc_done,
   input  logic [BBOX_W-1:0]        calc_bbox,
   output logic                     calc_read_done,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [BBOX_W-1:0]        rsp_bbox,
   output logic                     rsp_err
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ID_W-1:0]  r_last;
   logic [ID_W-1:0]  r_id;
   logic [VTX_W-1:0] r_pts;
   bbox_t            r_bbox;
   logic [ID_W-1:0]  w_win;
   logic             w_found;
   logic             w_grant;
   logic             w_timeout;
   logic [VTX_W-1:0] w_req_pts [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pts
      assign w_req_pts[g] = req_pts[g*VTX_W +: VTX_W];
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_picker (
      .i_req   (req_valid),
      .i_last  (r_last),
      .o_idx   (w_win),
      .o_found (w_found)
   );

`ifdef BBOX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign rsp_err   = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (r_state == ST_WAIT_CALC) begin
         if (calc_done) begin
            r_cnt <= '0;
            r_err <= 1'b0;
         end else if (w_timeout) begin
            r_cnt <= '0;
            r_err <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
`else
   logic [31:0] w_unused_timeout;
   assign w_unused_timeout = TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
   assign rsp_err          = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Grant is gated by rst_n so req_ready reads low for the whole reset window.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      w_grant     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (rst_n && calc_ready && w_found) begin
               w_grant          = 1'b1;
               req_ready[w_win] = 1'b1;
               w_state_nxt      = ST_ISSUE;
            end
         end
         ST_ISSUE:     w_state_nxt = ST_WAIT_CALC;
         ST_WAIT_CALC: if (calc_done || w_timeout) w_state_nxt = ST_RESPOND;
         ST_RESPOND:   if (rsp_ready) w_state_nxt = ST_RELEASE;
         ST_RELEASE:   w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= ID_W'(NUM_REQ - 1);
         r_id   <= '0;
         r_pts  <= '0;
         r_bbox <= '0;
      end else begin
         if (w_grant) begin
            r_id  <= w_win;
            r_pts <= w_req_pts[w_win];
         end
         if (r_state == ST_WAIT_CALC) begin
            if (calc_done)      r_bbox <= calc_bbox;
            else if (w_timeout) r_bbox <= '0;
         end
         if (r_state == ST_RELEASE) r_last <= r_id;
      end
   end

   assign calc_data_valid = (r_state == ST_ISSUE);
   assign calc_read_done  = (r_state == ST_RELEASE);
   assign rsp_valid       = (r_state == ST_RESPOND);
   assign calc_pts        = r_pts;
   assign rsp_id          = r_id;
   assign rsp_bbox        = {r_bbox[MAX_Y], r_bbox[MIN_Y], r_bbox[MAX_X], r_bbox[MIN_X]};

endmodule
